kypd_scan_ctrl: RTL and testbench



---
 rtl/kypd_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_kypd_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl: scan sequencer for the 4x4 PmodKYPD keypad.
// Drives one column low at a time, samples the synchronized active-low rows,
// classifies each full sweep (none / one key / several keys), debounces the
// sweep results and emits a registered, one-cycle key event with a hex code.
// Optional feature macro: KYPD_REPEAT_EN (auto-repeat of the held key).
module kypd_scan_ctrl #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CCNT_W = $clog2(SCAN_CYCLES);
    localparam int RUN_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CCNT_W-1:0] CCNT_LAST = CCNT_W'(SCAN_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(DEBOUNCE_SCANS);

    // Sweep result classes
    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_ONE   = 2'b01;
    localparam logic [1:0] RES_MULTI = 2'b10;

    // Active-low column drive pattern for column index c.
    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] v;
        case (c)
            2'd0:    v = 4'b1110;
            2'd1:    v = 4'b1101;
            2'd2:    v = 4'b1011;
            2'd3:    v = 4'b0111;
            default: v = 4'b1110;
        endcase
        return v;
    endfunction

    // Hex legend of the key at position {column, row}.
    function automatic logic [3:0] key_map(input logic [3:0] pos);
        logic [3:0] v;
        case (pos)
            4'h0:    v = 4'h1;
            4'h1:    v = 4'h4;
            4'h2:    v = 4'h7;
            4'h3:    v = 4'h0;
            4'h4:    v = 4'h2;
            4'h5:    v = 4'h5;
            4'h6:    v = 4'h8;
            4'h7:    v = 4'hF;
            4'h8:    v = 4'h3;
            4'h9:    v = 4'h6;
            4'hA:    v = 4'h9;
            4'hB:    v = 4'hE;
            4'hC:    v = 4'hA;
            4'hD:    v = 4'hB;
            4'hE:    v = 4'hC;
            4'hF:    v = 4'hD;
            default: v = 4'h0;
        endcase
        return v;
    endfunction

    // Row synchronizer
    logic [3:0] row_meta_r;
    logic [3:0] row_sync_r;

    // Scan state
    logic [1:0]        cidx_r;
    logic [CCNT_W-1:0] ccnt_r;
    logic [3:0]        col_r;
    logic              col_done_s;
    logic              sweep_done_s;

    // Column samples of the current sweep (column 3 is taken live)
    logic [3:0] slot0_r;
    logic [3:0] slot1_r;
    logic [3:0] slot2_r;

    // Sweep classification
    logic [15:0] lows_s;
    logic [4:0]  cnt_s;
    logic [3:0]  pos_s;
    logic [1:0]  res_kind_s;
    logic [3:0]  res_code_s;

    // Debounce state
    logic [1:0]       last_kind_r;
    logic [3:0]       last_code_r;
    logic [RUN_W-1:0] run_r;
    logic [RUN_W-1:0] run_next_s;
    logic             same_s;
    logic             run_full_s;
    logic             press_s;
    logic             release_s;
    logic             repeat_s;

    // Output registers
    logic [3:0] key_code_r;
    logic       key_down_r;
    logic       key_valid_r;

    assign col_done_s   = (ccnt_r == CCNT_LAST);
    assign sweep_done_s = col_done_s && (cidx_r == 2'd3);

    assign col       = col_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_down  = key_down_r;

    // Two-flop synchronizer on the asynchronous keypad rows (idle = pulled up).
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= row;
            row_sync_r <= row_meta_r;
        end
    end

    // Column scan: hold each column for SCAN_CYCLES cycles, then advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cidx_r <= 2'd0;
            ccnt_r <= {CCNT_W{1'b0}};
            col_r  <= 4'b1110;
        end else if (col_done_s) begin
            cidx_r <= cidx_r + 2'd1;
            ccnt_r <= {CCNT_W{1'b0}};
            col_r  <= col_drive(cidx_r + 2'd1);
        end else begin
            ccnt_r <= ccnt_r + CCNT_W'(1);
        end
    end

    // Capture the settled row pattern at the end of columns 0..2.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_r <= 4'hF;
            slot1_r <= 4'hF;
            slot2_r <= 4'hF;
        end else if (col_done_s) begin
            case (cidx_r)
                2'd0:    slot0_r <= row_sync_r;
                2'd1:    slot1_r <= row_sync_r;
                2'd2:    slot2_r <= row_sync_r;
                default: slot0_r <= slot0_r;
            endcase
        end else begin
            slot0_r <= slot0_r;
        end
    end

    // Classify the full sweep: count pressed positions and locate the last one.
    always_comb begin
        lows_s = ~{row_sync_r, slot2_r, slot1_r, slot0_r};
        cnt_s  = 5'd0;
        pos_s  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (lows_s[i]) begin
                cnt_s = cnt_s + 5'd1;
                pos_s = 4'(i);
            end else begin
                cnt_s = cnt_s;
            end
        end
        if (cnt_s == 5'd0) begin
            res_kind_s = RES_NONE;
        end else if (cnt_s == 5'd1) begin
            res_kind_s = RES_ONE;
        end else begin
            res_kind_s = RES_MULTI;
        end
        res_code_s = key_map(pos_s);
    end

    // Run-length of identical sweep results and the accept decisions.
    always_comb begin
        same_s = (res_kind_s == last_kind_r) &&
                 ((res_kind_s != RES_ONE) || (res_code_s == last_code_r));
        if (!same_s) begin
            run_next_s = RUN_ONE;
        end else if (run_r == RUN_FULL) begin
            run_next_s = RUN_FULL;
        end else begin
            run_next_s = run_r + RUN_ONE;
        end
        run_full_s = (run_next_s == RUN_FULL);
        press_s    = run_full_s && (res_kind_s == RES_ONE) &&
                     (!key_down_r || (res_code_s != key_code_r));
        release_s  = run_full_s && (res_kind_s == RES_NONE) && key_down_r;
    end

`ifdef KYPD_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

    logic [REP_W-1:0] rep_cnt_r;
    logic [REP_W-1:0] rep_next_s;
    logic             hold_s;

    // Count sweeps that keep showing the accepted key; fire every REPEAT_SCANS.
    always_comb begin
        hold_s     = key_down_r && (res_kind_s == RES_ONE) && (res_code_s == key_code_r);
        repeat_s   = 1'b0;
        rep_next_s = {REP_W{1'b0}};
        if (hold_s) begin
            if (rep_cnt_r == REP_LAST) begin
                repeat_s   = 1'b1;
                rep_next_s = {REP_W{1'b0}};
            end else begin
                rep_next_s = rep_cnt_r + REP_W'(1);
            end
        end else begin
            rep_next_s = {REP_W{1'b0}};
        end
    end

    // Repeat sweep counter, advanced once per sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_r <= {REP_W{1'b0}};
        end else if (sweep_done_s) begin
            rep_cnt_r <= rep_next_s;
        end else begin
            rep_cnt_r <= rep_cnt_r;
        end
    end
`else
    // Repeat disabled: the pulse is tied off. The parameter stays referenced
    // so both builds accept the same parameter set; it folds to a constant.
    localparam logic REP_CFG = (REPEAT_SCANS > 0);
    assign repeat_s = 1'b0 & REP_CFG;
`endif

    // Debounce registers and key outputs, updated at the end of each sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_kind_r <= RES_NONE;
            last_code_r <= 4'h0;
            run_r       <= {RUN_W{1'b0}};
            key_code_r  <= 4'h0;
            key_down_r  <= 1'b0;
            key_valid_r <= 1'b0;
        end else if (sweep_done_s) begin
            last_kind_r <= res_kind_s;
            last_code_r <= res_code_s;
            run_r       <= run_next_s;
            key_valid_r <= press_s | repeat_s;
            if (press_s) begin
                key_code_r <= res_code_s;
                key_down_r <= 1'b1;
            end else if (release_s) begin
                key_down_r <= 1'b0;
            end else begin
                key_down_r <= key_down_r;
            end
        end else begin
            key_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// tb_kypd_scan_ctrl: directed bench for kypd_scan_ctrl with a small keypad
// model (a pressed key pulls its row low while its column is driven low).
module tb_kypd_scan_ctrl;

    localparam int SC    = 8;
    localparam int DB    = 3;
    localparam int RP    = 4;
    localparam int SWEEP = 4 * SC;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    // pressed[c*4 + r] = key at column c, row r held down
    logic [15:0] pressed = 16'h0000;

    int total = 0;
    int bad   = 0;

    int         ev_count   = 0;
    logic [3:0] ev_code    = 4'h0;
    int         dbl_count  = 0;
    logic       prev_valid = 1'b0;

    kypd_scan_ctrl #(
        .SCAN_CYCLES   (SC),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_SCANS  (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // Keypad model
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4 + r] && (col[c] == 1'b0)) row[r] = 1'b0;
            end
        end
    end

    // Event monitor
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            ev_count <= ev_count + 1;
            ev_code  <= key_code;
        end
        if ((prev_valid === 1'b1) && (key_valid === 1'b1)) dbl_count <= dbl_count + 1;
        prev_valid <= key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_event(input int base, input int bound, output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        while (!seen && (waited < bound)) begin
            tick(1);
            waited++;
            if (ev_count != base) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        pressed = 16'h0000;
        tick(3);
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b want=%b", col, 4'b1110); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL reset_down got=%b want=0", key_down); end
        total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h want=0", key_code); end
        rst = 1'b0;
    endtask

    task automatic test_idle;
        logic [3:0] exp_col [0:3];
        int base;
        exp_col[0] = 4'b1110;
        exp_col[1] = 4'b1101;
        exp_col[2] = 4'b1011;
        exp_col[3] = 4'b0111;
        base = ev_count;
        for (int i = 0; i < 4; i++) begin
            tick(4);
            total++; if (col !== exp_col[i]) begin bad++; $display("FAIL idle_col%0d got=%b want=%b", i, col, exp_col[i]); end
            tick(4);
        end
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL idle_wrap got=%b want=1110", col); end
        tick(2 * SWEEP);
        total++; if (ev_count !== base) begin bad++; $display("FAIL idle_events got=%0d want=%0d", ev_count, base); end
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL idle_down got=%b want=0", key_down); end
    endtask

    task automatic test_press5;
        int base; bit seen; int waited;
        base    = ev_count;
        pressed = 16'h0020;
        wait_event(base, 140, seen, waited);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL press5_timeout got=%0d want=event", waited); end
        total++; if (ev_code !== 4'h5) begin bad++; $display("FAIL press5_code got=%h want=5", ev_code); end
        tick(1);
        total++; if (key_down !== 1'b1) begin bad++; $display("FAIL press5_down got=%b want=1", key_down); end
        tick(4 * SWEEP);
        total++; if (ev_count !== base + 1) begin bad++; $display("FAIL press5_count got=%0d want=%0d", ev_count - base, 1); end
        total++; if (key_down !== 1'b1) begin bad++; $display("FAIL press5_held got=%b want=1", key_down); end
        pressed = 16'h0000;
        tick(5 * SWEEP);
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL press5_release got=%b want=0", key_down); end
        total++; if (key_code !== 4'h5) begin bad++; $display("FAIL press5_codehold got=%h want=5", key_code); end
        total++; if (ev_count !== base + 1) begin bad++; $display("FAIL press5_relcount got=%0d want=%0d", ev_count - base, 1); end
    endtask

    task automatic test_bounce;
        int base; bit seen; int waited;
        base = ev_count;
        for (int i = 0; i < 5; i++) begin
            pressed = 16'h0020;
            tick(SWEEP);
            pressed = 16'h0000;
            tick(SWEEP);
        end
        total++; if (ev_count !== base) begin bad++; $display("FAIL bounce_events got=%0d want=0", ev_count - base); end
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL bounce_down got=%b want=0", key_down); end
        pressed = 16'h0020;
        wait_event(base, 140, seen, waited);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL bounce_timeout got=%0d want=event", waited); end
        total++; if (ev_code !== 4'h5) begin bad++; $display("FAIL bounce_code got=%h want=5", ev_code); end
        tick(2 * SWEEP);
        total++; if (ev_count !== base + 1) begin bad++; $display("FAIL bounce_count got=%0d want=1", ev_count - base); end
        pressed = 16'h0000;
        tick(5 * SWEEP);
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL bounce_release got=%b want=0", key_down); end
    endtask

    task automatic test_multi;
        int base; bit seen; int waited;
        base    = ev_count;
        pressed = 16'h8001;
        tick(6 * SWEEP);
        total++; if (ev_count !== base) begin bad++; $display("FAIL multi_events got=%0d want=0", ev_count - base); end
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL multi_down got=%b want=0", key_down); end
        pressed = 16'h0001;
        wait_event(base, 160, seen, waited);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL multi_timeout got=%0d want=event", waited); end
        total++; if (ev_code !== 4'h1) begin bad++; $display("FAIL multi_code got=%h want=1", ev_code); end
        total++; if (waited < 2 * SWEEP) begin bad++; $display("FAIL multi_restart got=%0d want>=%0d", waited, 2 * SWEEP); end
        pressed = 16'h0000;
        tick(5 * SWEEP);
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL multi_release got=%b want=0", key_down); end
    endtask

    task automatic test_back_to_back;
        int base; bit seen; int waited;
        base    = ev_count;
        pressed = 16'h0020;
        wait_event(base, 140, seen, waited);
        total++; if (ev_code !== 4'h5) begin bad++; $display("FAIL b2b_first got=%h want=5", ev_code); end
        base    = ev_count;
        pressed = 16'h0200;
        wait_event(base, 200, seen, waited);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=%0d want=event", waited); end
        total++; if (ev_code !== 4'h6) begin bad++; $display("FAIL b2b_code got=%h want=6", ev_code); end
        tick(1);
        total++; if (key_down !== 1'b1) begin bad++; $display("FAIL b2b_down got=%b want=1", key_down); end
        pressed = 16'h0000;
        tick(5 * SWEEP);
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL b2b_release got=%b want=0", key_down); end
    endtask

    task automatic test_reset_mid;
        int base; bit seen; int waited; int n;
        base    = ev_count;
        pressed = 16'h0080;
        wait_event(base, 140, seen, waited);
        total++; if (ev_code !== 4'hF) begin bad++; $display("FAIL rmid_pre got=%h want=f", ev_code); end
        n = 0;
        while ((col !== 4'b1011) && (n < 40)) begin
            tick(1);
            n++;
        end
        total++; if (col !== 4'b1011) begin bad++; $display("FAIL rmid_colwait got=%b want=1011", col); end
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL rmid_col got=%b want=1110", col); end
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL rmid_down got=%b want=0", key_down); end
        total++; if (key_code !== 4'h0) begin bad++; $display("FAIL rmid_code got=%h want=0", key_code); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", key_valid); end
        base = ev_count;
        wait_event(base, 160, seen, waited);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rmid_timeout got=%0d want=event", waited); end
        total++; if (ev_code !== 4'hF) begin bad++; $display("FAIL rmid_fresh got=%h want=f", ev_code); end
        pressed = 16'h0000;
        tick(5 * SWEEP);
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL rmid_release got=%b want=0", key_down); end
    endtask

    task automatic test_repeat;
        int base; int exp_n;
`ifdef KYPD_REPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        base    = ev_count;
        pressed = 16'h1000;
        tick(20 * SWEEP);
        pressed = 16'h0000;
        tick(5 * SWEEP);
        total++; if (ev_count - base !== exp_n) begin bad++; $display("FAIL repeat_count got=%0d want=%0d", ev_count - base, exp_n); end
        total++; if (ev_code !== 4'hA) begin bad++; $display("FAIL repeat_code got=%h want=a", ev_code); end
        total++; if (key_down !== 1'b0) begin bad++; $display("FAIL repeat_release got=%b want=0", key_down); end
        total++; if (dbl_count !== 0) begin bad++; $display("FAIL valid_double got=%0d want=0", dbl_count); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_idle();
        test_press5();
        test_bounce();
        test_multi();
        test_back_to_back();
        test_reset_mid();
        test_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
